// File: rtl/storage_pkg.sv
// Shared definitions for the storage bank: legal parameter ranges, the
// default hold time before a stored value loses its charge, and the helper
// that sizes the per-channel age counter.
package storage_pkg;

   localparam int CH_MIN        = 1;
   localparam int CH_MAX        = 64;
   localparam int DW_MIN        = 1;
   localparam int DW_MAX        = 16;
   localparam int NG_MIN        = 1;
   localparam int NG_MAX        = 4;
   localparam int DECAY_MIN     = 1;
   localparam int DECAY_MAX     = 65535;
   localparam int DECAY_DEFAULT = 1024;

   // Counter must represent every value from 0 through decay.
   function automatic int age_width(input int decay);
      return $clog2(decay + 1);
   endfunction

endpackage

// File: rtl/storage_decay_cell.sv
// One storage channel: holds a DW-bit value and, when decay is built in,
// replaces it with DECAY_VAL after DECAY consecutive unloaded cycles.
//
// Build option: STORAGE_DECAY_EN. When defined, the decay timer is present.
// When undefined, the cell is a plain gated register and stale stays 0.
//
// Ports:
//   eclk  - clock, rising edge
//   erst  - asynchronous active-high reset
//   load  - load enable (gate AND already taken by the parent)
//   d     - data to load
//   q     - stored value, registered
//   stale - value has decayed since the last load, registered
module storage_decay_cell
   import storage_pkg::*;
#(
   parameter int            DW        = 1,
   parameter int            DECAY     = DECAY_DEFAULT,
   parameter logic [DW-1:0] DECAY_VAL = '0
) (
   input  logic          eclk,
   input  logic          erst,
   input  logic          load,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] q,
   output logic          stale
);

   logic [DW-1:0] q_q, q_d;

`ifdef STORAGE_DECAY_EN
   localparam int            AW        = age_width(DECAY);
   localparam logic [AW-1:0] LEFT_FULL = AW'(DECAY);

   // The age is kept as cycles remaining until decay: loading (or reset)
   // refills it to DECAY, and reaching 1 on an unloaded edge is the decay
   // edge. Zero means already decayed, so the cell simply holds.
   logic [AW-1:0] left_q, left_d;
   logic          stale_q, stale_d;

   always_comb begin
      q_d     = q_q;
      stale_d = stale_q;
      left_d  = left_q;
      if (load) begin
         q_d     = d;
         stale_d = 1'b0;
         left_d  = LEFT_FULL;
      end else if (left_q == AW'(1)) begin
         q_d     = DECAY_VAL;
         stale_d = 1'b1;
         left_d  = '0;
      end else if (left_q != '0) begin
         left_d  = left_q - AW'(1);
      end
   end

   always_ff @(posedge eclk or posedge erst) begin
      if (erst) begin
         q_q     <= '0;
         stale_q <= 1'b0;
         left_q  <= LEFT_FULL;
      end else begin
         q_q     <= q_d;
         stale_q <= stale_d;
         left_q  <= left_d;
      end
   end

   assign stale = stale_q;
`else
   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = d;
      end
   end

   always_ff @(posedge eclk or posedge erst) begin
      if (erst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign stale = 1'b0;
`endif

   assign q = q_q;

endmodule

// File: rtl/storage_bank_decay.sv
// Bank of CH independent storage channels with gated loading and optional
// charge-loss decay, plus a saturating count of all loads.
//
// Build option: STORAGE_DECAY_EN enables per-channel decay timers
// (see storage_decay_cell); undefined gives hold-forever channels.
//
// Ports:
//   eclk     - clock, rising edge
//   erst     - asynchronous active-high reset
//   d        - write data, channel c at [c*DW +: DW]
//   g        - gate inputs, channel c at [c*NG +: NG]; all high loads it
//   q        - stored values, registered
//   stale    - per-channel decayed flag, registered
//   load_cnt - total loads since reset, saturating at 255
module storage_bank_decay
   import storage_pkg::*;
#(
   parameter int            CH        = 8,
   parameter int            DW        = 1,
   parameter int            NG        = 2,
   parameter int            DECAY     = DECAY_DEFAULT,
   parameter logic [DW-1:0] DECAY_VAL = '0
) (
   input  logic             eclk,
   input  logic             erst,
   input  logic [CH*DW-1:0] d,
   input  logic [CH*NG-1:0] g,
   output logic [CH*DW-1:0] q,
   output logic [CH-1:0]    stale,
   output logic [7:0]       load_cnt
);

   if (CH < CH_MIN || CH > CH_MAX || DW < DW_MIN || DW > DW_MAX ||
       NG < NG_MIN || NG > NG_MAX || DECAY < DECAY_MIN || DECAY > DECAY_MAX) begin : g_bad_params
      $error("storage_bank_decay: parameter out of range");
   end

   logic [CH-1:0] load_en;

   always_comb begin
      load_en = '0;
      for (int c = 0; c < CH; c++) begin
         load_en[c] = &g[c*NG +: NG];
      end
   end

   for (genvar c = 0; c < CH; c++) begin : g_cell
      storage_decay_cell #(
         .DW        (DW),
         .DECAY     (DECAY),
         .DECAY_VAL (DECAY_VAL)
      ) u_cell (
         .eclk  (eclk),
         .erst  (erst),
         .load  (load_en[c]),
         .d     (d[c*DW +: DW]),
         .q     (q[c*DW +: DW]),
         .stale (stale[c])
      );
   end

   // Nine bits covers 255 plus up to 64 loads in one edge before clamping.
   logic [7:0] load_cnt_q, load_cnt_d;
   logic [8:0] cnt_sum;

   always_comb begin
      cnt_sum = {1'b0, load_cnt_q};
      for (int c = 0; c < CH; c++) begin
         cnt_sum = cnt_sum + 9'(load_en[c]);
      end
      load_cnt_d = (cnt_sum > 9'd255) ? 8'd255 : cnt_sum[7:0];
   end

   always_ff @(posedge eclk or posedge erst) begin
      if (erst) begin
         load_cnt_q <= '0;
      end else begin
         load_cnt_q <= load_cnt_d;
      end
   end

   assign load_cnt = load_cnt_q;

endmodule

// File: doc/storage_bank_decay.md
STORAGE_BANK_DECAY -- requirements
Module: storage_bank_decay

Interface
REQ-001 SHALL have parameter CH, default 8: number of independent storage channels, 1..64.
REQ-002 SHALL have parameter DW, default 1: data bits per channel, 1..16.
REQ-003 SHALL have parameter NG, default 2: gate inputs per channel, 1..4.
REQ-004 SHALL have parameter DECAY, default 1024: hold cycles before charge loss, 1..65535.
REQ-005 SHALL have parameter DECAY_VAL, default 0: per-bit value, DW wide, that a decayed channel reads.
REQ-006 SHALL have port eclk, input, 1: the only clock; all state updates on its rising edge.
REQ-007 SHALL have port erst, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port d, input, CH*DW: write data; channel c occupies bits [c*DW +: DW].
REQ-009 SHALL have port g, input, CH*NG: gate inputs; channel c occupies bits [c*NG +: NG].
REQ-010 SHALL have port q, output, CH*DW: stored value per channel, registered.
REQ-011 SHALL have port stale, output, CH: channel has decayed since its last load, registered.
REQ-012 SHALL have port load_cnt, output, 8: total loads, saturating.

Function
REQ-013 SHALL define channel c load-enable as the AND of all NG bits of its gate slice.
REQ-014 SHALL, on a load-enable edge, set q slice to the d slice with one-cycle latency, clear stale[c] and set the channel age counter to 0.
REQ-015 SHALL, without a load, hold q and increment the age counter by 1 per cycle, saturating at DECAY.
REQ-016 SHALL, on the edge where age goes from DECAY-1 to DECAY, set the q slice to DECAY_VAL and stale[c] to 1 in the same edge.
REQ-017 SHALL, with age already at DECAY, hold q at DECAY_VAL and stale at 1 with no further change.
REQ-018 SHALL give load priority over decay when both fall on the same edge: q=d, stale=0, age=0.
REQ-019 SHALL treat each channel independently; any mix of simultaneous loads is legal.
REQ-020 SHALL size the age counter as clog2(DECAY+1) bits; DECAY=1 makes an unloaded channel decay on the first unloaded edge.
REQ-021 SHALL increment load_cnt by the number of channels loaded that edge, saturating at 255 with no wrap.
REQ-022 SHALL produce no combinational path from d or g to q, stale or load_cnt.

Reset
REQ-023 SHALL, while erst=1 and independent of eclk, force q=0, stale=0, all ages=0 and load_cnt=0.
REQ-024 SHALL deassert erst cleanly mid-hold: the age count restarts from 0 and no decay occurs until DECAY unloaded cycles after release.
REQ-025 SHALL respond to a load on the first eclk edge after erst falls.

Configuration
REQ-026 SHALL honour macro STORAGE_DECAY_EN: when it is defined, the age counters and the REQ-015..REQ-018 behaviour are present.
REQ-027 SHALL, when STORAGE_DECAY_EN is undefined, build no age counters, hold q indefinitely (same as a plain gated latch) and tie stale to 0; REQ-013, REQ-014 and REQ-021 still apply.

Structure
REQ-028 SHALL place the parameter range limits, the counter-width function and the default DECAY constant in shared package storage_pkg.
REQ-029 SHALL instantiate one sub-module storage_decay_cell per channel, holding q slice, stale and age; the load counter and popcount stay in the top level.

Verification (CH=4, DW=2, NG=2, DECAY=4, DECAY_VAL=2'b10, macro defined unless noted)
REQ-030 SHALL cover reset: pulse erst between edges -> q=0, stale=0 and load_cnt=0 immediately, with no eclk edge.
REQ-031 SHALL cover a basic load: g[1:0]=11, d[1:0]=01 for one edge -> q[1:0]=01 next cycle and stale[0]=0; g=01 only -> no load.
REQ-032 SHALL cover decay: after loading ch0=01, hold 3 edges -> q=01; 4th edge -> q[1:0]=10 and stale[0]=1; remains so for 10 more edges.
REQ-033 SHALL cover the load/decay race: load ch0 on exactly the 4th idle edge with d=11 -> q=11, stale=0, and decay is next due 4 edges later.
REQ-034 SHALL cover load count saturation: all 4 channels load every edge for 70 edges -> load_cnt reads 255, not wrapped.
REQ-035 SHALL cover the macro undefined: load ch2=11, idle 100 edges -> q[5:4]=11 and stale=0 throughout.
